// File: rtl/io_bus_master_8_pkg.sv
// rtl/io_bus_master_8_pkg.sv - shared constants and types for the I/O bus poll master
package io_bus_master_8_pkg;

    localparam logic [7:0] SW_LO = 8'h00;
    localparam logic [7:0] SW_HI = 8'h01;
    localparam logic [7:0] BTN   = 8'h02;

    localparam int STEP_W = 4;
    typedef logic [STEP_W-1:0] step_t;

    // Transaction order: three reads, two LED writes, four display writes
    localparam step_t STEP_SW_LO  = 4'd0;
    localparam step_t STEP_SW_HI  = 4'd1;
    localparam step_t STEP_BTN    = 4'd2;
    localparam step_t STEP_LED_LO = 4'd3;
    localparam step_t STEP_LED_HI = 4'd4;
    localparam step_t STEP_DISP0  = 4'd5;
    localparam step_t STEP_LAST   = 4'd8;

    localparam int BTN_C = 0;
    localparam int BTN_D = 4;

    typedef enum logic [2:0] {
        IDLE,
        RA,
        RC,
        WS,
        WP,
        WH,
        DONE
    } state_t;

endpackage

// File: rtl/io_bus_master_8_if.sv
// rtl/io_bus_master_8_if.sv - 8-bit local I/O bus between initiator and peripheral
interface io_bus_master_8_if;
    logic [7:0] addr;
    logic [7:0] data_out;
    logic [7:0] data_in;
    logic       we;

    modport master (
        output addr,
        output data_out,
        output we,
        input  data_in
    );

    modport slave (
        input  addr,
        input  data_out,
        input  we,
        output data_in
    );
endinterface

// File: rtl/io_bus_master_8_seg7.sv
// rtl/io_bus_master_8_seg7.sv - hex nibble to active-low {g,f,e,d,c,b,a} segment code
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/io_bus_master_8.sv
// rtl/io_bus_master_8.sv - periodic poll of switches/buttons, mirrored to LEDs and hex displays
module io_bus_master_8
    import io_bus_master_8_pkg::*;
#(
    parameter int         POLL_DIV  = 100000,
    parameter logic [7:0] LED_BASE  = 8'h08,
    parameter logic [7:0] DISP_BASE = 8'h80
) (
    input  logic                     clk,
    input  logic                     reset,
    io_bus_master_8_if.master        bus,
    output logic [15:0]              sw_val,
    output logic [4:0]               btn_val,
    output logic                     busy,
    output logic                     poll_done
);

    localparam int              DIV_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    state_t     state, state_d;
    step_t      step, step_d;
    logic [7:0] sw_lo, sw_lo_d, sw_hi, sw_hi_d;
    logic [15:0] sw_val_d;
    logic [4:0]  btn_val_d;

    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic       we_q, we_d, busy_d, poll_done_d;
    logic [7:0] word_addr, word_data;
    logic [3:0] nibble;
    logic [6:0] seg;

    assign bus.addr     = addr_q;
    assign bus.data_out = data_q;
    assign bus.we       = we_q;

    // Free-running so the poll period stays exact regardless of FSM activity
    always_ff @(posedge clk) begin
        if (reset || div_cnt == DIV_LAST) div_cnt <= '0;
        else                              div_cnt <= div_cnt + DIV_W'(1);
    end

    always_comb begin
        state_d   = state;
        step_d    = step;
        sw_lo_d   = sw_lo;
        sw_hi_d   = sw_hi;
        sw_val_d  = sw_val;
        btn_val_d = btn_val;
        unique case (state)
            IDLE: begin
                if (div_cnt == DIV_LAST) begin
                    state_d = RA;
                    step_d  = STEP_SW_LO;
                end
            end
            RA: state_d = RC;
            RC: begin
                case (step)
                    STEP_SW_LO: sw_lo_d = bus.data_in;
                    STEP_SW_HI: sw_hi_d = bus.data_in;
                    default: begin
                        sw_val_d  = {sw_hi, sw_lo};
                        btn_val_d = bus.data_in[4:0];
                    end
                endcase
                state_d = (step == STEP_BTN) ? WS : RA;
                step_d  = step + step_t'(1);
            end
            WS: state_d = WP;
            WP: state_d = WH;
            WH: begin
                if (step == STEP_LAST || (step == STEP_LED_HI && btn_val[BTN_C])) begin
                    state_d = DONE;
                end else begin
                    state_d = WS;
                    step_d  = step + step_t'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leftmost display shows the most significant nibble
    always_comb begin
        nibble = sw_val_d[3:0];
        case (step_d)
            4'd5:    nibble = sw_val_d[15:12];
            4'd6:    nibble = sw_val_d[11:8];
            4'd7:    nibble = sw_val_d[7:4];
            default: nibble = sw_val_d[3:0];
        endcase
    end

    hex_to_seg7 u_seg (
        .nibble (nibble),
        .seg    (seg)
    );

    always_comb begin
        word_addr = '0;
        word_data = '0;
        case (step_d)
            STEP_SW_LO: word_addr = SW_LO;
            STEP_SW_HI: word_addr = SW_HI;
            STEP_BTN:   word_addr = BTN;
            STEP_LED_LO: begin
                word_addr = LED_BASE;
                word_data = sw_val_d[7:0];
            end
            STEP_LED_HI: begin
                word_addr = LED_BASE + 8'd1;
                word_data = sw_val_d[15:8];
            end
            default: begin
                word_addr = DISP_BASE + {4'd0, step_d - STEP_DISP0};
                word_data = btn_val_d[BTN_D] ? 8'hFF : {1'b1, seg};
            end
        endcase
    end

    // Bus pins are registered from the next state so we never glitches
    always_comb begin
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        poll_done_d = (state_d == DONE);
        we_d        = (state_d == WP);
        addr_d      = busy_d ? word_addr : 8'h00;
        data_d      = (state_d == WS || state_d == WP || state_d == WH) ? word_data : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            sw_lo     <= '0;
            sw_hi     <= '0;
            sw_val    <= '0;
            btn_val   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            poll_done <= 1'b0;
        end else begin
            state     <= state_d;
            step      <= step_d;
            sw_lo     <= sw_lo_d;
            sw_hi     <= sw_hi_d;
            sw_val    <= sw_val_d;
            btn_val   <= btn_val_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy      <= busy_d;
            poll_done <= poll_done_d;
        end
    end

endmodule

// File: tb/tb_io_bus_master_8.sv
// tb/tb_io_bus_master_8.sv - randomized self-checking bench for io_bus_master_8
module tb_io_bus_master_8;

    localparam int         POLL_DIV = 32;
    localparam logic [7:0] TB_LED   = 8'h08;
    localparam logic [7:0] TB_DISP  = 8'h80;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw_val;
    logic [4:0]  btn_val;
    logic        busy;
    logic        poll_done;

    logic [15:0] sw;
    logic [4:0]  btn_in;
    logic [6:0]  seg_ref [16];
    logic [15:0] model_sw;
    logic [4:0]  model_btn;

    int cyc = 0;
    int mark = 0;
    int checks = 0;
    int failures = 0;

    io_bus_master_8_if bus ();

    io_bus_master_8 #(
        .POLL_DIV  (POLL_DIV),
        .LED_BASE  (TB_LED),
        .DISP_BASE (TB_DISP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sw_val    (sw_val),
        .btn_val   (btn_val),
        .busy      (busy),
        .poll_done (poll_done)
    );

    // Peripheral register file: reads are combinational in addr
    assign bus.data_in = (bus.addr == 8'h00) ? sw[7:0]  :
                         (bus.addr == 8'h01) ? sw[15:8] :
                         (bus.addr == 8'h02) ? {3'b000, btn_in} : 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_poll(input logic [15:0] sw_a, input logic [15:0] sw_b, input logic [4:0] btn);
        logic [15:0] sw_exp;
        logic [15:0] exp_q[$];
        logic [15:0] got_q[$];
        logic [3:0]  nib;
        logic [7:0]  pa, pd;
        logic        pw;
        bit          found, swapped;
        int          bc, exp_busy;

        sw_exp = {sw_b[15:8], sw_a[7:0]};
        exp_q.push_back({TB_LED, sw_exp[7:0]});
        exp_q.push_back({TB_LED + 8'd1, sw_exp[15:8]});
        if (!btn[0]) begin
            for (int k = 0; k < 4; k++) begin
                nib = sw_exp[15 - 4*k -: 4];
                exp_q.push_back({TB_DISP + 8'(k), btn[4] ? 8'hFF : {1'b1, seg_ref[nib]}});
            end
        end
        exp_busy = btn[0] ? 12 : 24;

        sw = sw_a;
        btn_in = btn;
        found = 0;
        for (int i = 0; i < 2*POLL_DIV; i++) begin
            @(negedge clk);
            if (busy) begin
                found = 1;
                break;
            end
        end
        check_eq("poll_start", 32'(found), 32'd1);
        if (!found) return;
        check_eq("poll_period", cyc - mark, POLL_DIV);
        mark = cyc;

        pa = 8'h00; pd = 8'h00; pw = 1'b0;
        bc = 0; swapped = 0;
        while (busy && bc < 40) begin
            bc++;
            if (bc == 1) check_eq("done_low_busy", 32'(poll_done), 32'd0);
            if (bc == 6) check_eq("sw_val_held", 32'(sw_val), 32'(model_sw));
            if (bc == 7) begin
                check_eq("sw_val_upd", 32'(sw_val), 32'(sw_exp));
                check_eq("btn_val_upd", 32'(btn_val), 32'(btn));
            end
            if (bus.we) check_eq("we_single", 32'(pw), 32'd0);
            if (bus.we && !pw) begin
                check_eq("ws_addr_stable", 32'(bus.addr), 32'(pa));
                check_eq("ws_data_stable", 32'(bus.data_out), 32'(pd));
                got_q.push_back({bus.addr, bus.data_out});
            end
            if (!bus.we && pw) begin
                check_eq("wh_addr_hold", 32'(bus.addr), 32'(pa));
                check_eq("wh_data_hold", 32'(bus.data_out), 32'(pd));
            end
            if (!swapped && bus.addr == 8'h01) begin
                sw = sw_b;
                swapped = 1;
            end
            pa = bus.addr;
            pd = bus.data_out;
            pw = bus.we;
            @(negedge clk);
        end

        check_eq("busy_cycles", bc, exp_busy);
        check_eq("poll_done", 32'(poll_done), 32'd1);
        check_eq("done_we", 32'(bus.we), 32'd0);
        @(negedge clk);
        check_eq("poll_done_end", 32'(poll_done), 32'd0);
        check_eq("idle_addr", 32'(bus.addr), 32'd0);
        check_eq("idle_data", 32'(bus.data_out), 32'd0);
        check_eq("idle_we", 32'(bus.we), 32'd0);
        check_eq("wr_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq("wr_addr_data", 32'(got_q[i]), 32'(exp_q[i]));
        end
        model_sw = sw_exp;
        model_btn = btn;
        check_eq("sw_val_post", 32'(sw_val), 32'(model_sw));
        check_eq("btn_val_post", 32'(btn_val), 32'(model_btn));
    endtask

    task automatic check_reset_state();
        check_eq("rst_addr", 32'(bus.addr), 32'd0);
        check_eq("rst_data", 32'(bus.data_out), 32'd0);
        check_eq("rst_we", 32'(bus.we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(poll_done), 32'd0);
        check_eq("rst_sw_val", 32'(sw_val), 32'd0);
        check_eq("rst_btn_val", 32'(btn_val), 32'd0);
    endtask

    task automatic reset_mid_write();
        bit found;
        sw = 16'h5A5A;
        btn_in = 5'd0;
        found = 0;
        for (int i = 0; i < 3*POLL_DIV; i++) begin
            @(negedge clk);
            if (bus.we) begin
                found = 1;
                break;
            end
        end
        check_eq("t1_we_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state();
        mark = cyc;
        model_sw = '0;
        model_btn = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        logic [4:0]  r;
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_sw = '0;
        model_btn = '0;
        reset = 1'b1;
        sw = '0;
        btn_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        mark = cyc;

        run_poll(16'hA5C3, 16'hA5C3, 5'b00000);
        run_poll(16'h1234, 16'h1234, 5'b00001);
        run_poll(16'hFFFF, 16'hFFFF, 5'b10000);
        run_poll(16'h12EF, 16'hAB34, 5'b00000);
        reset_mid_write();
        run_poll(16'h0F3C, 16'h0F3C, 5'b00110);

        for (int n = 0; n < 10; n++) begin
            a = 16'($urandom);
            b = $urandom_range(0, 1) ? 16'($urandom) : a;
            r = 5'($urandom_range(0, 31));
            run_poll(a, b, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
